// File: rtl/multi_event_counter_pkg.sv
// avc_cnt_pkg: shared constants and helpers for the multi-channel event counter.
//   CNT_WRAP / CNT_SAT  : overflow mode (SAT parameter)
//   EV_LEVEL / EV_EDGE  : event mode (EDGE parameter)
//   slice_lo()          : low bit index of a channel inside a packed CH*W bus
package avc_cnt_pkg;

    localparam int unsigned CNT_WRAP = 0;
    localparam int unsigned CNT_SAT  = 1;
    localparam int unsigned EV_LEVEL = 0;
    localparam int unsigned EV_EDGE  = 1;

    function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned width);
        return idx * width;
    endfunction

endpackage

// File: rtl/multi_event_counter_cnt_channel.sv
// cnt_channel: one W-bit event counter channel.
// Optional feature macro: STIM_SYNC_EN (adds a 2-flop synchroniser on stim).
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   en               count enable
//   stim             stimulus level
//   clr              synchronous clear (count, hit, ovf); drops this cycle's event
//   target [W-1:0]   terminal-count compare value
//   count  [W-1:0]   current count
//   hit              sticky: an increment produced target
//   ovf              sticky: an increment was attempted at all-ones
module cnt_channel
    import avc_cnt_pkg::*;
#(
    parameter int unsigned W    = 6,
    parameter int unsigned SAT  = CNT_WRAP,
    parameter int unsigned EDGE = EV_EDGE
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         stim,
    input  logic         clr,
    input  logic [W-1:0] target,
    output logic [W-1:0] count,
    output logic         hit,
    output logic         ovf
);

    logic         stim_s;
    logic         stim_q;
    logic         ev;
    logic         inc;
    logic         at_max;
    logic [W-1:0] nxt;

`ifdef STIM_SYNC_EN
    logic sync1;
    logic sync2;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= stim;
            sync2 <= sync1;
        end
    end

    always_comb stim_s = sync2;
`else
    always_comb stim_s = stim;
`endif

    generate
        if (EDGE == EV_EDGE) begin : g_edge
            always_comb ev = stim_s & ~stim_q;
        end else begin : g_level
            always_comb ev = stim_s;
        end
    endgenerate

    always_comb begin
        inc    = en & ev & ~clr;
        at_max = (count == '1);
        if (at_max) begin
            nxt = (SAT == CNT_SAT) ? count : '0;
        end else begin
            nxt = count + W'(1);
        end
    end

    // stim_q tracks the (possibly synchronised) stimulus every cycle so that
    // toggling en or clr never manufactures an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            stim_q <= 1'b0;
            count  <= '0;
            hit    <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            stim_q <= stim_s;
            if (clr) begin
                count <= '0;
                hit   <= 1'b0;
                ovf   <= 1'b0;
            end else if (inc) begin
                count <= nxt;
                if (at_max) begin
                    ovf <= 1'b1;
                end
                if (nxt == target) begin
                    hit <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/multi_event_counter.sv
// multi_event_counter: CH independent W-bit stimulus event counters with
// shared terminal-count target. Optional feature macro: STIM_SYNC_EN.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   en                  global count enable
//   stim  [CH-1:0]      per-channel stimulus level
//   clr   [CH-1:0]      per-channel synchronous clear
//   target[W-1:0]       common terminal-count value
//   count [CH*W-1:0]    packed counts, channel i at [i*W +: W]
//   hit   [CH-1:0]      sticky terminal-count flags
//   ovf   [CH-1:0]      sticky overflow / saturation flags
module multi_event_counter
    import avc_cnt_pkg::*;
#(
    parameter int unsigned CH   = 2,
    parameter int unsigned W    = 6,
    parameter int unsigned SAT  = CNT_WRAP,
    parameter int unsigned EDGE = EV_EDGE
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [CH-1:0]   stim,
    input  logic [CH-1:0]   clr,
    input  logic [W-1:0]    target,
    output logic [CH*W-1:0] count,
    output logic [CH-1:0]   hit,
    output logic [CH-1:0]   ovf
);

    generate
        for (genvar i = 0; i < CH; i++) begin : g_ch
            cnt_channel #(
                .W    (W),
                .SAT  (SAT),
                .EDGE (EDGE)
            ) u_ch (
                .clk    (clk),
                .rst    (rst),
                .en     (en),
                .stim   (stim[i]),
                .clr    (clr[i]),
                .target (target),
                .count  (count[slice_lo(i, W) +: W]),
                .hit    (hit[i]),
                .ovf    (ovf[i])
            );
        end
    endgenerate

endmodule

// File: tb/tb_multi_event_counter.sv
// Bench for multi_event_counter: three instances (edge/wrap, edge/saturate,
// level/wrap) share stimulus; directed scenarios plus a randomized run
// against an integer reference model.
module tb_multi_event_counter;

    localparam int CH   = 2;
    localparam int W    = 6;
    localparam int NI   = 3;
    localparam int MAXV = (1 << W) - 1;
`ifdef STIM_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [CH-1:0] stim;
    logic [CH-1:0] clr;
    logic [W-1:0]  target;

    logic [CH*W-1:0] cnt0, cnt1, cnt2;
    logic [CH-1:0]   hit0, hit1, hit2, ovf0, ovf1, ovf2;
    logic [CH*W-1:0] dcnt [NI];
    logic [CH-1:0]   dhit [NI];
    logic [CH-1:0]   dovf [NI];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    multi_event_counter #(.CH(CH), .W(W), .SAT(0), .EDGE(1)) u_wrap (
        .clk(clk), .rst(rst), .en(en), .stim(stim), .clr(clr), .target(target),
        .count(cnt0), .hit(hit0), .ovf(ovf0));
    multi_event_counter #(.CH(CH), .W(W), .SAT(1), .EDGE(1)) u_sat (
        .clk(clk), .rst(rst), .en(en), .stim(stim), .clr(clr), .target(target),
        .count(cnt1), .hit(hit1), .ovf(ovf1));
    multi_event_counter #(.CH(CH), .W(W), .SAT(0), .EDGE(0)) u_lvl (
        .clk(clk), .rst(rst), .en(en), .stim(stim), .clr(clr), .target(target),
        .count(cnt2), .hit(hit2), .ovf(ovf2));

    always_comb begin
        dcnt[0] = cnt0; dcnt[1] = cnt1; dcnt[2] = cnt2;
        dhit[0] = hit0; dhit[1] = hit1; dhit[2] = hit2;
        dovf[0] = ovf0; dovf[1] = ovf1; dovf[2] = ovf2;
    end

    // Reference model: integer counters following the counting rules directly.
    int unsigned m_cnt  [NI][CH];
    bit          m_hit  [NI][CH];
    bit          m_ovf  [NI][CH];
    bit          m_prev [NI][CH];
    bit [CH-1:0] m_d1, m_d2;

    always @(posedge clk) begin
        bit s, ev, is_sat, is_edge;
        int unsigned nv;
        if (rst) begin
            m_d1 <= '0;
            m_d2 <= '0;
            for (int m = 0; m < NI; m++)
                for (int i = 0; i < CH; i++) begin
                    m_cnt[m][i]  <= 0;
                    m_hit[m][i]  <= 1'b0;
                    m_ovf[m][i]  <= 1'b0;
                    m_prev[m][i] <= 1'b0;
                end
        end else begin
            m_d1 <= stim;
            m_d2 <= m_d1;
            for (int m = 0; m < NI; m++) begin
                is_sat  = (m == 1);
                is_edge = (m != 2);
                for (int i = 0; i < CH; i++) begin
`ifdef STIM_SYNC_EN
                    s = m_d2[i];
`else
                    s = stim[i];
`endif
                    ev = is_edge ? (s && !m_prev[m][i]) : s;
                    m_prev[m][i] <= s;
                    if (clr[i]) begin
                        m_cnt[m][i] <= 0;
                        m_hit[m][i] <= 1'b0;
                        m_ovf[m][i] <= 1'b0;
                    end else if (en && ev) begin
                        if (is_sat)
                            nv = (m_cnt[m][i] + 1 > MAXV) ? MAXV : m_cnt[m][i] + 1;
                        else
                            nv = (m_cnt[m][i] + 1) % (MAXV + 1);
                        if (m_cnt[m][i] == MAXV) m_ovf[m][i] <= 1'b1;
                        if (nv == target) m_hit[m][i] <= 1'b1;
                        m_cnt[m][i] <= nv;
                    end
                end
            end
        end
    end

    task automatic pulse0(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk) stim[0] = 1'b1;
            @(negedge clk) stim[0] = 1'b0;
        end
    endtask

    task automatic settle();
        repeat (2 + LAT) @(negedge clk);
    endtask

    task automatic clear(input logic [CH-1:0] mask);
        @(negedge clk) clr = mask;
        @(negedge clk) clr = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; clr = '0; stim = 2'b10; target = W'(MAXV);
        repeat (2) @(negedge clk);
        for (int m = 0; m < NI; m++) begin
            checks++;
            if (dcnt[m] !== '0) begin
                failures++;
                $display("FAIL reset_count inst%0d got=%h exp=0", m, dcnt[m]);
            end
            checks++;
            if (dhit[m] !== '0 || dovf[m] !== '0) begin
                failures++;
                $display("FAIL reset_flags inst%0d got hit=%b ovf=%b exp=0", m, dhit[m], dovf[m]);
            end
        end
        rst = 1'b0; en = 1'b1;
    endtask

    task automatic test_edge_count();
        pulse0(5);
        settle();
        checks++;
        if (dcnt[0][0 +: W] !== W'(5) || dcnt[0][W +: W] !== W'(1)) begin
            failures++;
            $display("FAIL edge_count got c0=%0d c1=%0d exp c0=5 c1=1", dcnt[0][0 +: W], dcnt[0][W +: W]);
        end
        checks++;
        if (dhit[0] !== 2'b00 || dovf[0] !== 2'b00) begin
            failures++;
            $display("FAIL edge_flags got hit=%b ovf=%b exp 00/00", dhit[0], dovf[0]);
        end
        checks++;
        if (dcnt[2][0 +: W] !== W'(5)) begin
            failures++;
            $display("FAIL level_pulse_count got=%0d exp=5", dcnt[2][0 +: W]);
        end
        stim[1] = 1'b0;
    endtask

    task automatic test_wrap();
        target = '0;
        clear(2'b01);
        pulse0(63);
        settle();
        checks++;
        if (dcnt[0][0 +: W] !== W'(63) || dhit[0][0] !== 1'b0 || dovf[0][0] !== 1'b0) begin
            failures++;
            $display("FAIL wrap_preload got c=%0d hit=%b ovf=%b exp 63/0/0", dcnt[0][0 +: W], dhit[0][0], dovf[0][0]);
        end
        pulse0(1);
        settle();
        checks++;
        if (dcnt[0][0 +: W] !== '0 || dovf[0][0] !== 1'b1 || dhit[0][0] !== 1'b1) begin
            failures++;
            $display("FAIL wrap_rollover got c=%0d hit=%b ovf=%b exp 0/1/1", dcnt[0][0 +: W], dhit[0][0], dovf[0][0]);
        end
        checks++;
        if (dcnt[1][0 +: W] !== W'(63) || dovf[1][0] !== 1'b1 || dhit[1][0] !== 1'b0) begin
            failures++;
            $display("FAIL sat_first got c=%0d hit=%b ovf=%b exp 63/0/1", dcnt[1][0 +: W], dhit[1][0], dovf[1][0]);
        end
    endtask

    task automatic test_saturate();
        pulse0(2);
        settle();
        checks++;
        if (dcnt[1][0 +: W] !== W'(63) || dovf[1][0] !== 1'b1) begin
            failures++;
            $display("FAIL sat_hold got c=%0d ovf=%b exp 63/1", dcnt[1][0 +: W], dovf[1][0]);
        end
        pulse0(1);
        settle();
        checks++;
        if (dcnt[1][0 +: W] !== W'(63)) begin
            failures++;
            $display("FAIL sat_extra got c=%0d exp=63", dcnt[1][0 +: W]);
        end
    endtask

    task automatic test_terminal();
        target = W'(10);
        clear(2'b01);
        pulse0(9);
        settle();
        checks++;
        if (dcnt[0][0 +: W] !== W'(9) || dhit[0][0] !== 1'b0) begin
            failures++;
            $display("FAIL term_before got c=%0d hit=%b exp 9/0", dcnt[0][0 +: W], dhit[0][0]);
        end
        pulse0(1);
        settle();
        checks++;
        if (dcnt[0][0 +: W] !== W'(10) || dhit[0][0] !== 1'b1) begin
            failures++;
            $display("FAIL term_hit got c=%0d hit=%b exp 10/1", dcnt[0][0 +: W], dhit[0][0]);
        end
        pulse0(2);
        settle();
        checks++;
        if (dcnt[0][0 +: W] !== W'(12) || dhit[0][0] !== 1'b1) begin
            failures++;
            $display("FAIL term_sticky got c=%0d hit=%b exp 12/1", dcnt[0][0 +: W], dhit[0][0]);
        end
    endtask

    task automatic test_clear_collision();
        // clr spans the cycle where the (possibly synchronised) edge lands
        @(negedge clk) begin stim[0] = 1'b1; clr = 2'b01; end
        @(negedge clk) stim[0] = 1'b0;
        repeat (LAT) @(negedge clk);
        clr = '0;
        settle();
        checks++;
        if (dcnt[0][0 +: W] !== '0 || dhit[0][0] !== 1'b0 || dovf[0][0] !== 1'b0) begin
            failures++;
            $display("FAIL clr_collide got c=%0d hit=%b ovf=%b exp 0/0/0", dcnt[0][0 +: W], dhit[0][0], dovf[0][0]);
        end
        pulse0(1);
        settle();
        checks++;
        if (dcnt[0][0 +: W] !== W'(1)) begin
            failures++;
            $display("FAIL clr_next_edge got c=%0d exp=1", dcnt[0][0 +: W]);
        end
        checks++;
        if (dcnt[0][W +: W] !== W'(1) || dhit[0][1] !== 1'b0 || dovf[0][1] !== 1'b0) begin
            failures++;
            $display("FAIL clr_ch1_indep got c=%0d hit=%b ovf=%b exp 1/0/0", dcnt[0][W +: W], dhit[0][1], dovf[0][1]);
        end
    endtask

    task automatic test_level_enable();
        target = W'(MAXV);
        clear(2'b11);
        for (int k = 0; k < 7 + LAT; k++) begin
            @(negedge clk);
            stim[0] = (k < 7);
            en = !(k >= 2 + LAT && k < 5 + LAT);
        end
        @(negedge clk) begin stim[0] = 1'b0; en = 1'b1; end
        settle();
        checks++;
        if (dcnt[2][0 +: W] !== W'(4)) begin
            failures++;
            $display("FAIL level_enable got c=%0d exp=4", dcnt[2][0 +: W]);
        end
        checks++;
        if (dcnt[0][0 +: W] !== W'(1)) begin
            failures++;
            $display("FAIL edge_long_high got c=%0d exp=1", dcnt[0][0 +: W]);
        end
    endtask

    task automatic test_random();
        @(negedge clk) rst = 1'b1;
        @(negedge clk) begin rst = 1'b0; stim = '0; clr = '0; en = 1'b1; target = W'($urandom_range(0, 20)); end
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            for (int m = 0; m < NI; m++)
                for (int i = 0; i < CH; i++) begin
                    checks++;
                    if (dcnt[m][i*W +: W] !== W'(m_cnt[m][i]) || dhit[m][i] !== m_hit[m][i]
                        || dovf[m][i] !== m_ovf[m][i]) begin
                        failures++;
                        $display("FAIL rand inst%0d ch%0d cyc%0d got c=%0d h=%b o=%b exp c=%0d h=%b o=%b",
                                 m, i, c, dcnt[m][i*W +: W], dhit[m][i], dovf[m][i],
                                 m_cnt[m][i], m_hit[m][i], m_ovf[m][i]);
                    end
                end
            stim = CH'($urandom);
            en   = ($urandom_range(0, 7) != 0);
            for (int i = 0; i < CH; i++) clr[i] = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 49) == 0) target = W'($urandom_range(0, MAXV));
        end
    endtask

    initial begin
        test_reset();
        test_edge_count();
        test_wrap();
        test_saturate();
        test_terminal();
        test_clear_collision();
        test_level_enable();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multi_event_counter.md
Name: multi_event_counter

Overview:
- Parametrised successor to the rotation-timing stimulus counter, for wheel/encoder tick counting in the T_Rot path.
- Counts stimulus events on CH independent channels, each W bits wide.
- Per channel: edge or level counting, wrap or saturate on overflow, and a sticky terminal-count flag compared against a shared target.
- Feeds the rotation controller, which polls `hit` to end a turn and clears channels per manoeuvre.

Parameters:
- CH, 2: number of independent channels.
- W, 6: counter width per channel, 2..16.
- SAT, 0: overflow mode. 0 = wrap at all-ones to 0; 1 = hold at all-ones.
- EDGE, 1: event mode. 1 = count rising edges of stim; 0 = count every cycle stim is high.

Ports:
- clk  in  1  single system clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  global count enable.
- stim  in  CH  per-channel stimulus level; bit i belongs to channel i.
- clr  in  CH  per-channel synchronous clear.
- target  in  W  common terminal-count value.
- count  out  CH*W  packed counts; channel i occupies bits [i*W +: W].
- hit  out  CH  sticky flag: channel reached target.
- ovf  out  CH  sticky flag: channel overflowed or saturated.

Behaviour:
- Reset (rst=1 at posedge): count, hit, ovf and the internal stim_q all go to 0. rst overrides every other input.
- stim_q[i] samples stim[i] every cycle, regardless of en or clr. Enabling therefore never creates a phantom edge.
- Event definition:
  - EDGE=1: ev[i] = stim[i] & ~stim_q[i].
  - EDGE=0: ev[i] = stim[i].
- A stim held high through reset release counts as one edge on the first cycle after reset (stim_q resets to 0).
- Increment condition: inc[i] = en & ev[i] & ~clr[i].
- Latency: count updates at the posedge where the event is sampled, and is visible the following cycle. No pipeline beyond that.
- Overflow at all-ones with inc[i]=1:
  - SAT=0: count becomes 0 and ovf[i] is set.
  - SAT=1: count holds all-ones and ovf[i] is set on each attempted increment at max.
- Terminal count:
  - hit[i] is set at the same posedge as an increment whose result equals target.
  - hit stays sticky until clr[i] or rst.
  - A target change does not retroactively set or clear hit.
  - With target=0, only a wrap (SAT=0) can set hit.
- clr[i] priority:
  - clr[i]=1 zeroes count[i], hit[i] and ovf[i], and blocks that cycle's event. The event is lost, not deferred.
  - stim_q still updates during clr.
- Channels are fully independent. Simultaneous events on all channels are all counted in the same cycle.
- en=0 freezes count and flags. clr still acts while en=0.
- There are no illegal states. Any value of count is reachable and well-defined.

Optional Feature:
- Macro: STIM_SYNC_EN.
- Defined: each stim bit first passes through a 2-flop synchroniser (reset to 0), with stim_q taken after it. Event-to-count latency grows by 2 cycles. Use this when stim comes from an asynchronous encoder pin.
- Undefined: stim is used directly, as specified above. stim must then be synchronous to clk.

Decomposition:
- Shared package avc_cnt_pkg holds:
  - mode constants CNT_WRAP=0, CNT_SAT=1, EV_LEVEL=0, EV_EDGE=1;
  - helper function for the packed-slice index.
- One sub-module, cnt_channel (single W-bit channel: edge detect, counter, hit, ovf), instantiated CH times by a generate loop in multi_event_counter.
- The synchroniser lives inside cnt_channel under the macro.

Test Plan:
1. Reset then edge count (CH=2, W=6, EDGE=1, SAT=0): rst for 2 cycles, then en=1 and 5 pulses on stim[0] while stim[1] is held high → count0=5, count1=1 (one edge at release), hit=0, ovf=0.
2. Wrap (SAT=0): preload count0 to 63 with 63 pulses, then one more pulse → count0=0, ovf[0]=1. With target=0 the same pulse also sets hit[0]=1.
3. Saturate (SAT=1): 66 pulses → count0=63, ovf[0]=1. A further pulse keeps count0=63.
4. Terminal count: target=10, 10 pulses → hit[0]=1 in the cycle after the 10th edge. 2 more pulses → count0=12, hit[0] still 1.
5. Clear vs event collision: assert clr[0] in the same cycle as a rising edge → count0=0, hit[0]=0, ovf[0]=0. The next edge gives count0=1. Channel 1 is unaffected throughout.
6. Level mode and enable (EDGE=0): stim high for 7 cycles with en low during 3 of them → count=4. With STIM_SYNC_EN defined, the first increment appears 2 cycles later.
